// File: rtl/motors_ctrl_responder_pkg.sv
// motors_ctrl_responder_pkg: shared FSM states and pen-level constants
package motors_ctrl_responder_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} motors_resp_state_e;
  localparam logic SERVO_UP = 1'b0;
  localparam logic SERVO_DOWN = 1'b1;
endpackage

// File: rtl/motors_ctrl_responder_step_axis_gen.sv
// motors_ctrl_responder_step_axis_gen: per-axis remaining-step counter and registered step pulse
module motors_ctrl_responder_step_axis_gen #(
  parameter int PULSE_NUM_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [PULSE_NUM_WIDTH-1:0] magnitude,
  input  logic                       phase,
  input  logic                       wrap,
  output logic                       step,
  output logic                       busy
);
  logic [PULSE_NUM_WIDTH-1:0] cnt, cnt_n;
  assign cnt_n = load ? magnitude : (wrap && cnt != '0) ? cnt - 1'b1 : cnt;
  assign busy = wrap ? (cnt > PULSE_NUM_WIDTH'(1)) : (cnt != '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      step <= 1'b0;
    end else begin
      cnt <= cnt_n;
      step <= phase && cnt_n != '0;
    end
  end
endmodule

// File: rtl/motors_ctrl_responder.sv
// motors_ctrl_responder: motor-side MotorsCtrl_IF slave executing one step/servo command per trigger
module motors_ctrl_responder
  import motors_ctrl_responder_pkg::*;
#(
  parameter int PULSE_NUM_WIDTH = 16,
  parameter int STEP_PERIOD_CYCLES = 1000,
  parameter int SERVO_SETTLE_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_x,
  input  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_y,
  input  logic                              servo_pos,
  input  logic                              trigger,
  output logic                              rdy,
  output logic                              done,
  output logic                              step_x,
  output logic                              dir_x,
  output logic                              step_y,
  output logic                              dir_y,
  output logic                              servo_pos_out
);
  localparam int CW = $clog2(STEP_PERIOD_CYCLES);
  localparam int SW = $clog2(SERVO_SETTLE_CYCLES + 1);
  motors_resp_state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scnt;
  logic [PULSE_NUM_WIDTH-1:0] mag_x, mag_y;
  logic accept, wrap, phase, busy_x, busy_y;
  assign accept = st == IDLE && trigger;
  assign wrap = st == RUN && cnt == CW'(STEP_PERIOD_CYCLES - 1);
  assign mag_x = $unsigned(pulse_num_x[PULSE_NUM_WIDTH-1] ? -pulse_num_x : pulse_num_x);
  assign mag_y = $unsigned(pulse_num_y[PULSE_NUM_WIDTH-1] ? -pulse_num_y : pulse_num_y);
  assign rdy = st == IDLE;
  assign done = st == DONE;
  always_comb begin
    st_n = st == IDLE   ? (trigger ? (servo_pos != servo_pos_out ? SETTLE : RUN) : IDLE) :
           st == SETTLE ? (scnt == SW'(SERVO_SETTLE_CYCLES - 1) ? RUN : SETTLE) :
           st == RUN    ? (!busy_x && !busy_y ? DONE : RUN) : IDLE;
    cnt_n = (st == RUN && st_n == RUN) ? (wrap ? '0 : cnt + 1'b1) : '0;
    phase = st_n == RUN && cnt_n < CW'(STEP_PERIOD_CYCLES / 2);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      scnt <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      servo_pos_out <= SERVO_UP;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      scnt <= st == SETTLE ? scnt + 1'b1 : '0;
      if (accept) begin
        dir_x <= pulse_num_x[PULSE_NUM_WIDTH-1];
        dir_y <= pulse_num_y[PULSE_NUM_WIDTH-1];
        servo_pos_out <= servo_pos;
      end
    end
  end
  motors_ctrl_responder_step_axis_gen #(.PULSE_NUM_WIDTH(PULSE_NUM_WIDTH)) u_axis_x (
    .clk(clk), .reset(reset), .load(accept), .magnitude(mag_x),
    .phase(phase), .wrap(wrap), .step(step_x), .busy(busy_x)
  );
  motors_ctrl_responder_step_axis_gen #(.PULSE_NUM_WIDTH(PULSE_NUM_WIDTH)) u_axis_y (
    .clk(clk), .reset(reset), .load(accept), .magnitude(mag_y),
    .phase(phase), .wrap(wrap), .step(step_y), .busy(busy_y)
  );
endmodule

// File: tb/tb_motors_ctrl_responder.sv
// tb_motors_ctrl_responder: directed self-checking bench for motors_ctrl_responder
module tb_motors_ctrl_responder;
  logic clk = 1'b0;
  logic reset, reset2;
  logic signed [15:0] pulse_num_x, pulse_num_y, pulse_num_x2;
  logic servo_pos, trigger, trigger2;
  logic rdy, done, step_x, dir_x, step_y, dir_y, servo_pos_out;
  logic rdy2, done2, step_x2, dir_x2, step_y2, dir_y2, servo_pos_out2;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  motors_ctrl_responder #(.PULSE_NUM_WIDTH(16), .STEP_PERIOD_CYCLES(4), .SERVO_SETTLE_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .pulse_num_x(pulse_num_x), .pulse_num_y(pulse_num_y),
    .servo_pos(servo_pos), .trigger(trigger), .rdy(rdy), .done(done),
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y), .servo_pos_out(servo_pos_out)
  );
  motors_ctrl_responder #(.PULSE_NUM_WIDTH(16), .STEP_PERIOD_CYCLES(2), .SERVO_SETTLE_CYCLES(1)) dut_long (
    .clk(clk), .reset(reset2), .pulse_num_x(pulse_num_x2), .pulse_num_y(16'sd0),
    .servo_pos(1'b0), .trigger(trigger2), .rdy(rdy2), .done(done2),
    .step_x(step_x2), .dir_x(dir_x2), .step_y(step_y2), .dir_y(dir_y2), .servo_pos_out(servo_pos_out2)
  );
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic issue(input logic signed [15:0] x, input logic signed [15:0] y, input logic sp);
    @(negedge clk);
    pulse_num_x = x;
    pulse_num_y = y;
    servo_pos = sp;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask
  task automatic watch(input int bound, input int poke, output int n_done, output int rx,
                       output int ry, output int first, output logic [15:0] patx);
    logic px, py;
    px = 1'b0;
    py = 1'b0;
    n_done = -1;
    rx = 0;
    ry = 0;
    first = -1;
    patx = '0;
    for (int i = 0; i < bound; i++) begin
      if (step_x && !px) rx++;
      if (step_y && !py) ry++;
      px = step_x;
      py = step_y;
      if ((step_x || step_y) && first < 0) first = i;
      if (i < 16) patx[i] = step_x;
      if (done) begin
        n_done = i;
        break;
      end
      if (i == poke) begin
        trigger = 1'b1;
        pulse_num_x = 16'sd5;
      end
      @(negedge clk);
      trigger = 1'b0;
    end
  endtask
  task automatic after_done(input string tag);
    check({tag, "_rdy_in_done"}, rdy, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_rdy_back"}, rdy, 1);
  endtask
  task automatic main_seq();
    int n, rx, ry, first, dcount;
    logic [15:0] patx;
    check("reset_rdy", rdy, 1);
    check("reset_done", done, 0);
    check("reset_steps", {step_x, step_y}, 0);
    check("reset_dirs", {dir_x, dir_y}, 0);
    check("reset_servo", servo_pos_out, 0);
    issue(16'sd3, 16'sd0, 1'b0);
    check("t1_rdy_low", rdy, 0);
    watch(100, -1, n, rx, ry, first, patx);
    check("t1_pattern", patx, 16'h0333);
    check("t1_done_at", n, 12);
    check("t1_rise_x", rx, 3);
    check("t1_rise_y", ry, 0);
    check("t1_dir_x", dir_x, 0);
    after_done("t1");
    issue(-16'sd2, 16'sd5, 1'b1);
    check("t2_servo", servo_pos_out, 1);
    watch(100, -1, n, rx, ry, first, patx);
    check("t2_pattern", patx, 16'hCC00);
    check("t2_first_step", first, 10);
    check("t2_done_at", n, 30);
    check("t2_rise_x", rx, 2);
    check("t2_rise_y", ry, 5);
    check("t2_dirs", {dir_x, dir_y}, 2'b10);
    after_done("t2");
    issue(16'sd0, 16'sd0, 1'b1);
    watch(20, -1, n, rx, ry, first, patx);
    check("t3_done_at", n, 1);
    check("t3_steps", rx + ry, 0);
    after_done("t3");
    issue(16'sd10, 16'sd0, 1'b1);
    watch(100, 5, n, rx, ry, first, patx);
    check("t5_ignored_rise_x", rx, 10);
    check("t5_done_at", n, 40);
    after_done("t5");
    issue(16'sd10, 16'sd0, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_step_before_reset", step_x, 1);
    check("t6_servo_before_reset", servo_pos_out, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rdy", rdy, 1);
    check("t6_step_x", step_x, 0);
    check("t6_servo", servo_pos_out, 0);
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (done || step_x) dcount++;
      @(negedge clk);
    end
    check("t6_no_done_or_steps", dcount, 0);
  endtask
  task automatic long_seq();
    int rx, n;
    logic px;
    @(negedge clk);
    pulse_num_x2 = -16'sd32768;
    trigger2 = 1'b1;
    @(negedge clk);
    trigger2 = 1'b0;
    check("t4_dir_x", dir_x2, 1);
    rx = 0;
    n = -1;
    px = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (step_x2 && !px) rx++;
      px = step_x2;
      if (done2) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    check("t4_rise_x", rx, 32768);
    check("t4_done_at", n, 65536);
  endtask
  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    trigger = 1'b0;
    trigger2 = 1'b0;
    pulse_num_x = '0;
    pulse_num_y = '0;
    pulse_num_x2 = '0;
    servo_pos = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reset2 = 1'b0;
    fork
      main_seq();
      long_seq();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
